// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm time registers and ring/snooze/auto-off FSM
//
// Compares the running time of day against a stored alarm time. On a match
// it rings for up to RING_SEC seconds. Optionally, the user can snooze for
// SNOOZE_MIN minutes before it re-rings.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   defined   : SNOOZE state and snooze counter are built
//   undefined : snooze_b is ignored, snoozing is tied 0
//
// Parameters
//   SNOOZE_MIN : snooze length in minutes (1..30)
//   RING_SEC   : maximum ring length in seconds (1..255)
//
// Ports
//   sig_1Hz   in   1 Hz clock; all state changes on its rising edge
//   reset_n   in   asynchronous active-low reset
//   hrs_ctr   in   current hour 0..23
//   min_ctr   in   current minute 0..59
//   sec_ctr   in   current second 0..59
//   alarm_en  in   alarm armed while high
//   set_hrs_b in   pulse: advance alarm hour (23 wraps to 0)
//   set_min_b in   pulse: advance alarm minute (59 wraps to 0, no carry)
//   snooze_b  in   pulse: snooze request while ringing
//   stop_b    in   pulse: stop request while ringing or snoozing
//   alarm_hrs out  stored alarm hour
//   alarm_min out  stored alarm minute
//   ring      out  registered, high while RINGING
//   snoozing  out  registered, high while SNOOZE

module alarm_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic       sig_1Hz,
    input  logic       reset_n,
    input  logic [4:0] hrs_ctr,
    input  logic [5:0] min_ctr,
    input  logic [5:0] sec_ctr,
    input  logic       alarm_en,
    input  logic       set_hrs_b,
    input  logic       set_min_b,
    input  logic       snooze_b,
    input  logic       stop_b,
    output logic [4:0] alarm_hrs,
    output logic [5:0] alarm_min,
    output logic       ring,
    output logic       snoozing
);

    localparam int RT_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(RING_SEC - 1);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_RINGING,
        S_SNOOZE
    } state_t;

    localparam int SN_W = $clog2(SNOOZE_MIN * 60);
    localparam logic [SN_W-1:0] SN_LOAD = SN_W'(SNOOZE_MIN * 60 - 1);

    logic [SN_W-1:0] snz_cnt_q;
    logic [SN_W-1:0] snz_cnt_d;
    logic            snoozing_q;
`else
    typedef enum logic {
        S_IDLE,
        S_RINGING
    } state_t;

    // snooze_b has no function in this build
    logic unused_snooze_b;
    assign unused_snooze_b = snooze_b;
`endif

    state_t          state_q;
    state_t          state_d;
    logic [RT_W-1:0] ring_tmr_q;
    logic [RT_W-1:0] ring_tmr_d;
    logic            ring_q;
    logic [4:0]      alarm_hrs_q;
    logic [4:0]      alarm_hrs_d;
    logic [5:0]      alarm_min_q;
    logic [5:0]      alarm_min_d;
    logic            hit;

    // Compare against the stored alarm time as it stands before this edge
    assign hit = (hrs_ctr == alarm_hrs_q) && (min_ctr == alarm_min_q) &&
                 (sec_ctr == 6'd0);

    // Alarm time setting: independent of FSM state, no minute-to-hour carry
    always_comb begin
        alarm_hrs_d = alarm_hrs_q;
        alarm_min_d = alarm_min_q;
        if (set_hrs_b) begin
            alarm_hrs_d = (alarm_hrs_q == 5'd23) ? 5'd0 : alarm_hrs_q + 5'd1;
        end
        if (set_min_b) begin
            alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
        end
    end

    always_ff @(posedge sig_1Hz or negedge reset_n) begin
        if (!reset_n) begin
            alarm_hrs_q <= 5'd0;
            alarm_min_q <= 6'd0;
        end else begin
            alarm_hrs_q <= alarm_hrs_d;
            alarm_min_q <= alarm_min_d;
        end
    end

    // Next-state logic; branches are ordered by transition priority
    always_comb begin
        state_d    = state_q;
        ring_tmr_d = ring_tmr_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        if (!alarm_en) begin
            state_d    = S_IDLE;
            ring_tmr_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        state_d    = S_RINGING;
                        ring_tmr_d = '0;
                    end
                end
                S_RINGING: begin
                    if (stop_b) begin
                        state_d    = S_IDLE;
                        ring_tmr_d = '0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze_b) begin
                        state_d    = S_SNOOZE;
                        snz_cnt_d  = SN_LOAD;
`endif
                    end else if (ring_tmr_q == RT_LAST) begin
                        state_d    = S_IDLE;
                        ring_tmr_d = '0;
                    end else begin
                        ring_tmr_d = ring_tmr_q + RT_W'(1);
                    end
                end
`ifdef ALARM_SNOOZE_EN
                S_SNOOZE: begin
                    if (stop_b) begin
                        state_d    = S_IDLE;
                        snz_cnt_d  = '0;
                    end else if (snz_cnt_q == '0) begin
                        state_d    = S_RINGING;
                        ring_tmr_d = '0;
                    end else begin
                        snz_cnt_d  = snz_cnt_q - SN_W'(1);
                    end
                end
`endif
                default: begin
                    state_d    = S_IDLE;
                    ring_tmr_d = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change with it
    always_ff @(posedge sig_1Hz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ring_tmr_q <= '0;
            ring_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
            snoozing_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ring_tmr_q <= ring_tmr_d;
            ring_q     <= (state_d == S_RINGING);
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
            snoozing_q <= (state_d == S_SNOOZE);
`endif
        end
    end

    assign alarm_hrs = alarm_hrs_q;
    assign alarm_min = alarm_min_q;
    assign ring      = ring_q;
`ifdef ALARM_SNOOZE_EN
    assign snoozing  = snoozing_q;
`else
    assign snoozing  = 1'b0;
`endif

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller that consumes the running time of day (hours, minutes, seconds counters) and raises a ring output when it matches a user-set alarm time. It sits directly downstream of the hours counter and the minute/second counters, on the same 1 Hz clock. It holds the alarm time, which button pulses can adjust. A three-state FSM handles ringing, snooze and auto-off.

## Interface
- `SNOOZE_MIN`, default 5: snooze length in minutes, legal range 1–30.
- `RING_SEC`, default 60: maximum ring duration in seconds before auto-off, legal range 1–255.

- `sig_1Hz` input 1: 1 Hz clock, all state on rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `hrs_ctr` input 5: current hour, 0–23.
- `min_ctr` input 6: current minute, 0–59.
- `sec_ctr` input 6: current second, 0–59.
- `alarm_en` input 1: level; alarm armed when 1.
- `set_hrs_b` input 1: one-cycle pulse; increments the alarm hour.
- `set_min_b` input 1: one-cycle pulse; increments the alarm minute.
- `snooze_b` input 1: one-cycle pulse; snooze request.
- `stop_b` input 1: one-cycle pulse; stop request.
- `alarm_hrs` output 5: stored alarm hour.
- `alarm_min` output 6: stored alarm minute.
- `ring` output 1: registered; 1 while in RINGING.
- `snoozing` output 1: registered; 1 while in SNOOZE.

## Operation
- Alarm time registers:
  - `set_hrs_b` increments the alarm hour 0→23, and 23 wraps to 0.
  - `set_min_b` increments the alarm minute 0→59, and 59 wraps to 0. It does not carry into the hour.
  - Both pulses may be applied in the same cycle; each register updates independently.
  - Setting is allowed in every FSM state and does not change the state.
- Match condition `hit` is `hrs_ctr==alarm_hrs && min_ctr==alarm_min && sec_ctr==0`, using the register values as they stand before the edge.
- FSM states:
  - IDLE: `ring`=0, `snoozing`=0.
  - RINGING: `ring`=1.
  - SNOOZE: `snoozing`=1.
- Transitions, in priority order, evaluated each edge:
  - Any state → IDLE when `alarm_en`=0.
  - RINGING/SNOOZE → IDLE when `stop_b`.
  - RINGING → SNOOZE when `snooze_b`. The snooze counter loads SNOOZE_MIN*60−1.
  - RINGING → IDLE when the ring timer equals RING_SEC−1 (auto-off).
  - SNOOZE → RINGING when the snooze counter equals 0. The ring timer clears.
  - IDLE → RINGING when `alarm_en && hit`. The ring timer clears.
- Counters:
  - Ring timer increments each cycle in RINGING. Width is clog2(RING_SEC), minimum 1.
  - Snooze counter decrements each cycle in SNOOZE. Width is clog2(SNOOZE_MIN*60).
- `hit` is ignored in RINGING and SNOOZE, so a second match cannot restart the ring timer.
- `snooze_b` in IDLE or SNOOZE is ignored. `stop_b` in IDLE is ignored.
- Changing the alarm time during SNOOZE does not cancel the pending re-ring.

## Timing
- Reset (`reset_n`=0, asynchronous) gives:
  - `alarm_hrs`=0, `alarm_min`=0.
  - `ring`=0, `snoozing`=0.
  - State IDLE, both counters 0.
- Release takes effect on the first rising edge after deassertion.
- Reset mid-ring or mid-snooze drops `ring`/`snoozing` immediately, combinationally through the async clear.
- Latency:
  - `hit` seen during cycle T gives `ring`=1 after edge T+1. The upstream counter shows hh:mm:01 at that point.
  - Pulse inputs take effect on the edge that samples them.
  - Alarm time outputs update on the same edge as the setting pulse.
- Ring duration without intervention is exactly RING_SEC cycles.
- Snooze from the `snooze_b` edge to re-ring is exactly SNOOZE_MIN*60 cycles.
- Midnight boundary: alarm 0:00 fires when the counters read 00:00:00, immediately after the 23:59:59 wrap.
- Alarm set to the current minute after second 0 has passed does not fire until the next day.

## Configuration
- Macro `ALARM_SNOOZE_EN`.
- Defined: snooze behaves as described above.
- Undefined:
  - SNOOZE state and snooze counter are not built.
  - `snooze_b` is ignored and `snoozing` is tied 0.
  - RINGING leaves only via `stop_b`, `alarm_en`=0 or auto-off.
  - The port list is unchanged.

## Test plan
- Reset, then 23 `set_hrs_b` pulses and 1 more: `alarm_hrs` reads 23, then 0. 60 `set_min_b` pulses: `alarm_min` wraps to 0, hour unchanged.
- Alarm 07:30, `alarm_en`=1, counters stepped 07:29:59 → 07:30:00: `ring` rises one edge later and stays high exactly 60 cycles, then IDLE.
- Alarm 07:30 ringing, `snooze_b` at cycle 10 of ring: `ring`=0, `snoozing`=1 for 300 cycles. `ring` then re-asserts for up to 60 cycles (macro defined).
- During RINGING, `stop_b` and `snooze_b` pulsed in the same cycle: state goes to IDLE, `snoozing` stays 0.
- In SNOOZE, `alarm_en` dropped: IDLE next edge, no re-ring after 300 cycles. With the macro undefined, `snooze_b` during ring has no effect.
- `reset_n` asserted mid-ring: `ring`=0 immediately, alarm time reads 00:00; no ring after release until the next match.
